ars_scalar_mult_ctrl: RTL and testbench

Parametrised MSB-first double-and-add controller for elliptic-curve scalar multiplication R = k·P over any field width. It takes the scalar and base point per job through a START/BUSY/DONE handshake. It drives external point-doubling and point-addition units through REQ/ACK handshakes and tracks the point at infinity. It replaces the fixed-233-bit, hard-wired-key top level and sits between the key/point source and the existing double/add datapaths.

---
 rtl/ars_pm_pkg.sv | 21 ++
 rtl/ars_key_cursor.sv | 36 +++
 rtl/ars_scalar_mult_ctrl.sv | 178 +++++++++++++++++
 tb/tb_ars_scalar_mult_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ars_pm_pkg.sv
// Shared definitions for the scalar-multiplication controller: FSM states,
// default widths and the bit-index width helper.
package ars_pm_pkg;

  localparam int unsigned DEF_W  = 233;
  localparam int unsigned DEF_KW = 233;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    DBL,
    ADD,
    FIN
  } pm_state_e;

  // Index counter width; never narrower than one bit so KW=1 still builds.
  function automatic int unsigned idx_w(input int unsigned kw);
    return (kw > 1) ? $clog2(kw) : 1;
  endfunction

endpackage

// File: rtl/ars_key_cursor.sv
// Key shadow register plus MSB-first bit cursor: presents key[IDX] and
// flags when IDX has reached bit 0.
module ars_key_cursor
  import ars_pm_pkg::*;
#(
  parameter int unsigned KW = DEF_KW,
  parameter int unsigned CW = idx_w(KW)
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          load,
  input  logic          dec,
  input  logic [KW-1:0] key,
  output logic          bit_out,
  output logic          last_bit
);

  logic [KW-1:0] key_q;
  logic [CW-1:0] idx_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      key_q <= '0;
      idx_q <= '0;
    end else if (load) begin
      key_q <= key;
      idx_q <= CW'(KW - 1);
    end else if (dec) begin
      idx_q <= idx_q - 1'b1;
    end
  end

  assign bit_out  = key_q[idx_q];
  assign last_bit = (idx_q == '0);

endmodule

// File: rtl/ars_scalar_mult_ctrl.sv
// MSB-first double-and-add controller for R = k*P; sequences external
// doubler/adder units and tracks the point at infinity in QINF.
module ars_scalar_mult_ctrl
  import ars_pm_pkg::*;
#(
  parameter int unsigned W  = DEF_W,
  parameter int unsigned KW = DEF_KW,
  parameter int unsigned CW = idx_w(KW)
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          START,
  input  logic [KW-1:0] KEY,
  input  logic [W-1:0]  PX,
  input  logic [W-1:0]  PY,
  output logic          BUSY,
  output logic          DONE,
  output logic [W-1:0]  RX,
  output logic [W-1:0]  RY,
  output logic          RINF,
  output logic          DBL_REQ,
  output logic [W-1:0]  DBL_X,
  output logic [W-1:0]  DBL_Y,
  input  logic          DBL_ACK,
  input  logic [W-1:0]  DBL_RX,
  input  logic [W-1:0]  DBL_RY,
  input  logic          DBL_RINF,
  output logic          ADD_REQ,
  output logic [W-1:0]  ADD_AX,
  output logic [W-1:0]  ADD_AY,
  output logic [W-1:0]  ADD_BX,
  output logic [W-1:0]  ADD_BY,
  input  logic          ADD_ACK,
  input  logic [W-1:0]  ADD_RX,
  input  logic [W-1:0]  ADD_RY,
  input  logic          ADD_RINF
);

  pm_state_e    state_q, state_d;
  logic [W-1:0] px_q, py_q;
  logic [W-1:0] qx_q, qy_q, qx_d, qy_d;
  logic         qinf_q, qinf_d;
  logic [W-1:0] rx_q, ry_q;
  logic         rinf_q;
  logic         load, dec, step, finish;
  logic         cur_bit, last_bit;

  ars_key_cursor #(.KW(KW), .CW(CW)) u_cursor (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .load     (load),
    .dec      (dec),
    .key      (KEY),
    .bit_out  (cur_bit),
    .last_bit (last_bit)
  );

  // REQ/ACK: REQ is high for the whole time the FSM sits in DBL/ADD, with
  // operands taken straight from the Q/P registers so they cannot move; an
  // ACK is consumed only in the matching state (including its first cycle),
  // and REQ drops on the following edge when the state advances.
  always_comb begin
    state_d = state_q;
    qx_d    = qx_q;
    qy_d    = qy_q;
    qinf_d  = qinf_q;
    load    = 1'b0;
    dec     = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (START) begin
          load    = 1'b1;
          qx_d    = '0;
          qy_d    = '0;
          qinf_d  = 1'b1;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (qinf_q) begin
          if (cur_bit) begin
            qx_d   = px_q;
            qy_d   = py_q;
            qinf_d = 1'b0;
          end
          step = 1'b1;
        end else begin
          state_d = DBL;
        end
      end
      DBL: begin
        if (DBL_ACK) begin
          qx_d   = DBL_RX;
          qy_d   = DBL_RY;
          qinf_d = DBL_RINF;
          if (!cur_bit) begin
            step = 1'b1;
          end else if (DBL_RINF) begin
            // O + P collapses to P without a trip through the adder.
            qx_d   = px_q;
            qy_d   = py_q;
            qinf_d = 1'b0;
            step   = 1'b1;
          end else begin
            state_d = ADD;
          end
        end
      end
      ADD: begin
        if (ADD_ACK) begin
          qx_d   = ADD_RX;
          qy_d   = ADD_RY;
          qinf_d = ADD_RINF;
          step   = 1'b1;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (step) begin
      if (last_bit) begin
        state_d = FIN;
      end else begin
        dec     = 1'b1;
        state_d = SCAN;
      end
    end
  end

  assign finish = step & last_bit;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      px_q    <= '0;
      py_q    <= '0;
      qx_q    <= '0;
      qy_q    <= '0;
      qinf_q  <= 1'b0;
      rx_q    <= '0;
      ry_q    <= '0;
      rinf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      qx_q    <= qx_d;
      qy_q    <= qy_d;
      qinf_q  <= qinf_d;
      if (load) begin
        px_q   <= PX;
        py_q   <= PY;
        rx_q   <= '0;
        ry_q   <= '0;
        rinf_q <= 1'b0;
      end else if (finish) begin
        // Result lands on FIN entry so it is valid in the DONE cycle.
        rx_q   <= qinf_d ? '0 : qx_d;
        ry_q   <= qinf_d ? '0 : qy_d;
        rinf_q <= qinf_d;
      end
    end
  end

  assign BUSY    = (state_q != IDLE);
  assign DONE    = (state_q == FIN);
  assign RX      = rx_q;
  assign RY      = ry_q;
  assign RINF    = rinf_q;
  assign DBL_REQ = (state_q == DBL);
  assign DBL_X   = qx_q;
  assign DBL_Y   = qy_q;
  assign ADD_REQ = (state_q == ADD);
  assign ADD_AX  = qx_q;
  assign ADD_AY  = qy_q;
  assign ADD_BX  = px_q;
  assign ADD_BY  = py_q;

endmodule

// File: tb/tb_ars_scalar_mult_ctrl.sv
// Bench for ars_scalar_mult_ctrl: points are integers mod n, so R = k*p mod n
// with 0 standing for infinity; doubler/adder models ACK after a delay.
module tb_ars_scalar_mult_ctrl;

  localparam int W  = 8;
  localparam int KW = 8;

  logic          CLK, RST_N, START;
  logic [KW-1:0] KEY;
  logic [W-1:0]  PX, PY;
  logic          BUSY, DONE, RINF;
  logic [W-1:0]  RX, RY;
  logic          DBL_REQ, DBL_ACK, DBL_RINF;
  logic [W-1:0]  DBL_X, DBL_Y, DBL_RX, DBL_RY;
  logic          ADD_REQ, ADD_ACK, ADD_RINF;
  logic [W-1:0]  ADD_AX, ADD_AY, ADD_BX, ADD_BY, ADD_RX, ADD_RY;

  ars_scalar_mult_ctrl #(.W(W), .KW(KW)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .KEY(KEY), .PX(PX), .PY(PY),
    .BUSY(BUSY), .DONE(DONE), .RX(RX), .RY(RY), .RINF(RINF),
    .DBL_REQ(DBL_REQ), .DBL_X(DBL_X), .DBL_Y(DBL_Y), .DBL_ACK(DBL_ACK),
    .DBL_RX(DBL_RX), .DBL_RY(DBL_RY), .DBL_RINF(DBL_RINF),
    .ADD_REQ(ADD_REQ), .ADD_AX(ADD_AX), .ADD_AY(ADD_AY), .ADD_BX(ADD_BX),
    .ADD_BY(ADD_BY), .ADD_ACK(ADD_ACK), .ADD_RX(ADD_RX), .ADD_RY(ADD_RY),
    .ADD_RINF(ADD_RINF)
  );

  typedef struct {
    logic [W-1:0] rx;
    logic [W-1:0] ry;
    logic         rinf;
    int           ndbl;
    int           nadd;
    int           lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0, n_fail = 0;
  int   n_mod = 251, dbl_dly = 0, add_dly = 0;
  int   cyc = 0, start_cyc = 0, dbl_cnt = 0, add_cnt = 0;
  int   done_cnt = 0, exp_done_cnt = 0;
  logic dbl_req_d = 1'b0, add_req_d = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] y_of(input int v);
    return W'(v) ^ 8'hA5;
  endfunction

  function automatic int msb_pos(input int k);
    int m = 0;
    for (int i = 0; i < KW; i++) if ((k >> i) & 1) m = i;
    return m;
  endfunction

  function automatic int pop_cnt(input int k);
    int c = 0;
    for (int i = 0; i < KW; i++) c += (k >> i) & 1;
    return c;
  endfunction

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // doubler model: 2q mod n, infinity when 0
  initial begin
    logic [W-1:0] x0, y0;
    int d, v;
    bit ok;
    DBL_ACK = 1'b0; DBL_RX = '0; DBL_RY = '0; DBL_RINF = 1'b0;
    forever begin
      @(negedge CLK);
      if (DBL_REQ && RST_N) begin
        x0 = DBL_X; y0 = DBL_Y;
        d  = (dbl_dly < 0) ? int'($urandom_range(3, 0)) : dbl_dly;
        ok = 1'b1;
        for (int i = 0; i < d; i++) begin
          @(negedge CLK);
          if (!DBL_REQ) begin ok = 1'b0; break; end
          check("dbl_x_stable", DBL_X, x0);
          check("dbl_y_stable", DBL_Y, y0);
        end
        if (ok) begin
          v = (2 * int'(x0)) % n_mod;
          DBL_RX = W'(v); DBL_RY = (v == 0) ? '0 : y_of(v);
          DBL_RINF = (v == 0); DBL_ACK = 1'b1;
          @(negedge CLK);
          DBL_ACK = 1'b0;
        end
      end
    end
  end

  // adder model: q + p mod n, infinity when 0
  initial begin
    logic [W-1:0] ax0, bx0;
    int d, v;
    bit ok;
    ADD_ACK = 1'b0; ADD_RX = '0; ADD_RY = '0; ADD_RINF = 1'b0;
    forever begin
      @(negedge CLK);
      if (ADD_REQ && RST_N) begin
        ax0 = ADD_AX; bx0 = ADD_BX;
        d   = (add_dly < 0) ? int'($urandom_range(3, 0)) : add_dly;
        ok  = 1'b1;
        for (int i = 0; i < d; i++) begin
          @(negedge CLK);
          if (!ADD_REQ) begin ok = 1'b0; break; end
          check("add_a_stable", ADD_AX, ax0);
          check("add_b_stable", ADD_BX, bx0);
        end
        if (ok) begin
          v = (int'(ax0) + int'(bx0)) % n_mod;
          ADD_RX = W'(v); ADD_RY = (v == 0) ? '0 : y_of(v);
          ADD_RINF = (v == 0); ADD_ACK = 1'b1;
          @(negedge CLK);
          ADD_ACK = 1'b0;
        end
      end
    end
  end

  // monitor: REQ counting and result scoreboard
  always @(negedge CLK) begin
    exp_t e;
    if (RST_N) begin
      if (DBL_REQ && !dbl_req_d) dbl_cnt++;
      if (ADD_REQ && !add_req_d) add_cnt++;
      if (DONE) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          check("done_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("rx", RX, e.rx);
          check("ry", RY, e.ry);
          check("rinf", RINF, e.rinf);
          if (e.ndbl >= 0) check("dbl_req_count", dbl_cnt, e.ndbl);
          if (e.nadd >= 0) check("add_req_count", add_cnt, e.nadd);
          if (e.lat >= 0) check("done_cycle", cyc - start_cyc + 1, e.lat);
        end
      end
    end
    dbl_req_d = DBL_REQ;
    add_req_d = ADD_REQ;
  end

  // driver tasks
  task automatic wait_idle(input int lim);
    int t = 0;
    while (BUSY && t < lim) begin
      @(negedge CLK);
      t++;
    end
    check("job_finished", BUSY, 0);
  endtask

  task automatic run_job(input int k, input int p, input int n, input int dd,
                         input int ad, input int ndbl, input int nadd,
                         input int lat, input bit glitch);
    exp_t e;
    int   v;
    n_mod = n; dbl_dly = dd; add_dly = ad;
    v      = (k * p) % n;
    e.rinf = (v == 0);
    e.rx   = e.rinf ? '0 : W'(v);
    e.ry   = e.rinf ? '0 : y_of(v);
    e.ndbl = ndbl; e.nadd = nadd; e.lat = lat;
    exp_q.push_back(e);
    exp_done_cnt++;
    @(negedge CLK);
    KEY = KW'(k); PX = W'(p); PY = y_of(p); START = 1'b1;
    @(posedge CLK);
    #1;
    start_cyc = cyc; dbl_cnt = 0; add_cnt = 0;
    @(negedge CLK);
    START = 1'b0;
    if (glitch) begin
      repeat (3) @(negedge CLK);
      KEY = ~KW'(k); PX = W'(p + 1); PY = y_of(p + 1); START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
    end
    wait_idle(2000);
    if (lat >= 0) check("busy_fall_cycle", cyc - start_cyc + 1, lat + 1);
    @(negedge CLK);
  endtask

  task automatic run_random(input int n);
    int k, p;
    k = $urandom_range(250, 0);
    p = $urandom_range(n - 1, 1);
    if (n == 251)
      run_job(k, p, n, -1, -1, (k == 0) ? 0 : msb_pos(k),
              (k == 0) ? 0 : pop_cnt(k) - 1, -1, 1'b0);
    else
      run_job(k, p, n, -1, -1, -1, -1, -1, 1'b0);
  endtask

  initial begin
    int t;
    RST_N = 1'b0; START = 1'b0; KEY = '0; PX = '0; PY = '0;
    #1;
    check("reset_busy", BUSY, 0);
    check("reset_done", DONE, 0);
    check("reset_dbl_req", DBL_REQ, 0);
    check("reset_add_req", ADD_REQ, 0);
    check("reset_rx", RX, 0);
    check("reset_rinf", RINF, 0);
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);

    run_job(8'h00, 5, 251, 0, 0, 0, 0, KW + 1, 1'b0);
    run_job(8'h01, 5, 251, 0, 0, 0, 0, KW + 1, 1'b0);
    run_job(8'hB5, 1, 251, 5, 5, 7, 4, -1, 1'b0);
    run_job(8'h03, 2, 4, 1, 1, 1, 0, -1, 1'b0);
    run_job(8'hB5, 3, 251, 0, 0, 7, 4, -1, 1'b0);
    run_job(8'h6B, 7, 251, 2, 1, 6, 4, -1, 1'b1);

    // reset while the doubler is still pending
    n_mod = 251; dbl_dly = 40; add_dly = 0;
    @(negedge CLK);
    KEY = 8'hB5; PX = 8'd1; PY = y_of(1); START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    t = 0;
    while (!DBL_REQ && t < 100) begin
      @(negedge CLK);
      t++;
    end
    check("dbl_req_before_reset", DBL_REQ, 1);
    #2;
    RST_N = 1'b0;
    #1;
    check("async_rst_dbl_req", DBL_REQ, 0);
    check("async_rst_busy", BUSY, 0);
    check("async_rst_done", DONE, 0);
    check("async_rst_rx", RX, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    run_job(8'h2D, 9, 251, 1, 2, 5, 3, -1, 1'b0);

    for (int i = 0; i < 8; i++) run_random(251);
    for (int i = 0; i < 6; i++) run_random($urandom_range(20, 2));

    repeat (3) @(negedge CLK);
    check("done_count", done_cnt, exp_done_cnt);
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
